pattern_match_ctrl: RTL

- Programmable serial pattern-match controller.
- Accepts a pattern of up to MAX_LEN bits through a config handshake, then consumes a valid/ready serial bit stream and detects overlapping occurrences of the pattern.
- Counts matches and reports completion after a programmed number of hits.
- Sits in front of serial-protocol monitors as the sequencing and configuration layer for runtime pattern detection, replacing fixed-pattern detectors.

---
 rtl/pattern_match_pkg.sv | 14 +
 rtl/pattern_shift_cmp.sv | 50 +++++
 rtl/pattern_match_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pattern_match_pkg.sv
// Shared types for the programmable serial pattern-match controller.
// Holds the controller state encoding and default sizing.
package pattern_match_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pattern_shift_cmp.sv
// Serial history shift register, saturating fill counter and
// len-masked compare of the post-shift history against the pattern.
module pattern_shift_cmp
    import pattern_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    // Only MAX_LEN-1 bits need storing: the newest bit comes from din.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;

    assign hist_n = {hist, din};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = (((hist_n ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_n[MAX_LEN-2:0];
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Pattern-match controller: config/stream handshakes, IDLE/RUN/DONE
// sequencing and the saturating match counter.
module pattern_match_ctrl
    import pattern_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               din_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    ctrl_state_e state_q, state_d;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match_q;
    logic               err_q;

    logic               cfg_fire;
    logic               bit_fire;
    logic               cfg_bad;
    logic               cmp_hit;
    logic [LEN_W-1:0]   fill;
    logic               seen;
    logic               hit;
    logic               last;

    // abort wins over both handshakes in the same cycle
    assign cfg_fire = cfg_valid && cfg_ready && !abort;
    assign bit_fire = din_valid && din_ready && !abort;
    assign cfg_bad  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));

    assign seen    = ({1'b0, fill} + 1'b1) >= {1'b0, len_q};
    assign hit     = bit_fire && cmp_hit && seen;
    assign cnt_inc = cnt_q + 1'b1;
    assign last    = (tgt_q != '0) && (cnt_inc == tgt_q);

    pattern_shift_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .clk      (clk),
        .reset    (reset),
        .shift_en (bit_fire),
        .clear    (abort || cfg_fire),
        .din      (din),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (cmp_hit),
        .fill     (fill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = (state_q != RUN);
        din_ready = (state_q == RUN);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        if (abort) begin
            state_d = IDLE;
        end else if (cfg_fire) begin
            state_d = cfg_bad ? IDLE : RUN;
        end else if (hit && last) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            match_q <= hit;
            if (cfg_fire) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                tgt_q <= cfg_target;
                cnt_q <= '0;
                err_q <= cfg_bad;
            end else if (hit && !(&cnt_q)) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign cfg_err     = err_q;

endmodule
